// File: rtl/aud_btm_trace_buf.sv
// BTM trace buffer: rebuilds full branch addresses from nibble frames into a FWFT FIFO.
// Optional per-entry timestamp when AUD_BTM_TIMESTAMP_EN is defined.
module aud_btm_trace_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_W       = 16
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  frm_valid_i,
    input  logic [1:0]            frm_type_i,
    input  logic [2:0]            frm_len_i,
    input  logic [31:0]           frm_data_i,
    input  logic                  rd_i,
    output logic [31:0]           rd_data_o,
    output logic [1:0]            rd_type_o,
`ifdef AUD_BTM_TIMESTAMP_EN
    output logic [TS_W-1:0]       rd_ts_o,
`endif
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    output logic [15:0]           drop_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || TS_W < 1) begin : g_bad_cfg
        $error("aud_btm_trace_buf: illegal DEPTH_LOG2 or TS_W");
    end

    logic [31:0]           mem_addr [DEPTH];
    logic [1:0]            mem_type [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [31:0]           last_addr;
    logic [31:0]           mask;
    logic [31:0]           new_addr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;

    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= frm_len_i) mask[4*i +: 4] = 4'hF;
        end
        new_addr = (last_addr & ~mask) | (frm_data_i & mask);
    end

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    // A pop at full frees the slot the simultaneous push lands in.
    assign push  = frm_valid_i && !clr_i && (!full || rd_i);
    assign pop   = rd_i && !empty && !clr_i;
    assign drop  = frm_valid_i && !clr_i && full && !rd_i;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i || clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            last_addr  <= '0;
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (frm_valid_i) last_addr <= new_addr;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (drop) begin
                ovf_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (push && !rst_i) begin
            mem_addr[wr_ptr] <= new_addr;
            mem_type[wr_ptr] <= frm_type_i;
        end
    end

`ifdef AUD_BTM_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk_sys_i) begin
        if (rst_i || clr_i) ts_cnt <= '0;
        else                ts_cnt <= ts_cnt + 1'b1;
    end

    always_ff @(posedge clk_sys_i) begin
        if (push && !rst_i) mem_ts[wr_ptr] <= ts_cnt;
    end

    assign rd_ts_o = empty ? '0 : mem_ts[rd_ptr];
`endif

    // Gate the head with empty so unreset memory never leaks to the outputs.
    assign rd_data_o = empty ? '0 : mem_addr[rd_ptr];
    assign rd_type_o = empty ? '0 : mem_type[rd_ptr];
    assign empty_o   = empty;
    assign full_o    = full;
    assign level_o   = level;

endmodule

// File: tb/tb_aud_btm_trace_buf.sv
// Directed bench for aud_btm_trace_buf, built with a 4-entry FIFO.
// Timestamp checks compile in only when AUD_BTM_TIMESTAMP_EN is defined.
module tb_aud_btm_trace_buf;

    logic        clk_sys_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        frm_valid_i = 1'b0;
    logic [1:0]  frm_type_i = '0;
    logic [2:0]  frm_len_i = '0;
    logic [31:0] frm_data_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_type_o;
`ifdef AUD_BTM_TIMESTAMP_EN
    logic [15:0] rd_ts_o;
`endif
    logic        empty_o;
    logic        full_o;
    logic [2:0]  level_o;
    logic        ovf_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    aud_btm_trace_buf #(.DEPTH_LOG2(2), .TS_W(16)) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .frm_valid_i (frm_valid_i),
        .frm_type_i  (frm_type_i),
        .frm_len_i   (frm_len_i),
        .frm_data_i  (frm_data_i),
        .rd_i        (rd_i),
        .rd_data_o   (rd_data_o),
        .rd_type_o   (rd_type_o),
`ifdef AUD_BTM_TIMESTAMP_EN
        .rd_ts_o     (rd_ts_o),
`endif
        .empty_o     (empty_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .ovf_o       (ovf_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk_sys_i);
        #1;
        rst_i       = 1'b0;
        clr_i       = 1'b0;
        frm_valid_i = 1'b0;
        rd_i        = 1'b0;
    endtask

    task automatic send(input logic [2:0] len, input logic [31:0] data,
                        input logic [1:0] typ, input logic rd, input logic clr);
        frm_valid_i = 1'b1;
        frm_len_i   = len;
        frm_data_i  = data;
        frm_type_i  = typ;
        rd_i        = rd;
        clr_i       = clr;
        tick();
    endtask

    task automatic pop();
        rd_i = 1'b1;
        tick();
    endtask

    task automatic flush();
        clr_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_flags got e=%b f=%b l=%0d want e=1 f=0 l=0",
                     empty_o, full_o, level_o);
        end
        checks++;
        if (ovf_o !== 1'b0 || drop_cnt_o !== 16'd0 || rd_data_o !== 32'd0 ||
            rd_type_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_outs got ovf=%b drop=%0d d=%h t=%0d want all 0",
                     ovf_o, drop_cnt_o, rd_data_o, rd_type_o);
        end
    endtask

    task automatic test_push_one();
        send(3'd7, 32'h01234567, 2'd2, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b0 || level_o !== 3'd1 || rd_data_o !== 32'h01234567 ||
            rd_type_o !== 2'd2) begin
            errors++;
            $display("FAIL push_one got e=%b l=%0d d=%h t=%0d want e=0 l=1 d=01234567 t=2",
                     empty_o, level_o, rd_data_o, rd_type_o);
        end
        pop();
        checks++;
        if (empty_o !== 1'b1 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL pop_one got e=%b l=%0d want e=1 l=0", empty_o, level_o);
        end
    endtask

    task automatic test_rebuild();
        send(3'd7, 32'h89ABCDEF, 2'd1, 1'b0, 1'b0);
        send(3'd3, 32'h0000BEEF, 2'd3, 1'b0, 1'b0);
        send(3'd0, 32'hFFFFFFF5, 2'd0, 1'b0, 1'b0);
        checks++;
        if (rd_data_o !== 32'h89ABCDEF || rd_type_o !== 2'd1 || level_o !== 3'd3) begin
            errors++;
            $display("FAIL rebuild_1 got d=%h t=%0d l=%0d want 89abcdef t=1 l=3",
                     rd_data_o, rd_type_o, level_o);
        end
        pop();
        checks++;
        if (rd_data_o !== 32'h89ABBEEF || rd_type_o !== 2'd3) begin
            errors++;
            $display("FAIL rebuild_2 got d=%h t=%0d want 89abbeef t=3", rd_data_o, rd_type_o);
        end
        pop();
        checks++;
        if (rd_data_o !== 32'h89ABBEE5 || rd_type_o !== 2'd0) begin
            errors++;
            $display("FAIL rebuild_mask got d=%h t=%0d want 89abbee5 t=0", rd_data_o, rd_type_o);
        end
        pop();
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        flush();
        for (int k = 1; k <= 6; k++) begin
            exp = 32'hA0000000 + 32'(k);
            send(3'd7, exp, 2'(k), 1'b0, 1'b0);
        end
        checks++;
        if (full_o !== 1'b1 || level_o !== 3'd4 || drop_cnt_o !== 16'd2 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow got f=%b l=%0d drop=%0d ovf=%b want f=1 l=4 drop=2 ovf=1",
                     full_o, level_o, drop_cnt_o, ovf_o);
        end
        for (int k = 1; k <= 4; k++) begin
            exp = 32'hA0000000 + 32'(k);
            checks++;
            if (rd_data_o !== exp || rd_type_o !== 2'(k)) begin
                errors++;
                $display("FAIL ovf_order%0d got d=%h t=%0d want d=%h t=%0d",
                         k, rd_data_o, rd_type_o, exp, k % 4);
            end
            pop();
        end
        pop();
        checks++;
        if (empty_o !== 1'b1 || level_o !== 3'd0 || rd_data_o !== 32'd0) begin
            errors++;
            $display("FAIL rd_empty got e=%b l=%0d d=%h want e=1 l=0 d=0",
                     empty_o, level_o, rd_data_o);
        end
        send(3'd0, 32'h0000000F, 2'd1, 1'b0, 1'b0);
        checks++;
        if (rd_data_o !== 32'hA000000F || level_o !== 3'd1 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL rebuild_after_drop got d=%h l=%0d ovf=%b want a000000f l=1 ovf=1",
                     rd_data_o, level_o, ovf_o);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        flush();
        for (int k = 1; k <= 4; k++) send(3'd7, 32'hB0000000 + 32'(k), 2'd0, 1'b0, 1'b0);
        send(3'd7, 32'hB0000005, 2'd3, 1'b1, 1'b0);
        checks++;
        if (level_o !== 3'd4 || full_o !== 1'b1 || drop_cnt_o !== 16'd0 ||
            ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got l=%0d f=%b drop=%0d ovf=%b want l=4 f=1 drop=0 ovf=0",
                     level_o, full_o, drop_cnt_o, ovf_o);
        end
        for (int k = 2; k <= 5; k++) begin
            exp = 32'hB0000000 + 32'(k);
            checks++;
            if (rd_data_o !== exp) begin
                errors++;
                $display("FAIL b2b_order%0d got %h want %h", k, rd_data_o, exp);
            end
            pop();
        end
        checks++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drained got e=%b want 1", empty_o);
        end
    endtask

    task automatic test_clear();
        flush();
        for (int k = 1; k <= 5; k++) send(3'd7, 32'hC0000000 + 32'(k), 2'd1, 1'b0, 1'b0);
        pop();
        checks++;
        if (level_o !== 3'd3 || ovf_o !== 1'b1 || drop_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL pre_clear got l=%0d ovf=%b drop=%0d want l=3 ovf=1 drop=1",
                     level_o, ovf_o, drop_cnt_o);
        end
        send(3'd7, 32'hFFFFFFFF, 2'd2, 1'b1, 1'b1);
        checks++;
        if (empty_o !== 1'b1 || level_o !== 3'd0 || ovf_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL clear got e=%b l=%0d ovf=%b drop=%0d want e=1 l=0 ovf=0 drop=0",
                     empty_o, level_o, ovf_o, drop_cnt_o);
        end
        send(3'd1, 32'h000000AB, 2'd2, 1'b0, 1'b0);
        checks++;
        if (rd_data_o !== 32'h000000AB || level_o !== 3'd1) begin
            errors++;
            $display("FAIL post_clear got d=%h l=%0d want 000000ab l=1", rd_data_o, level_o);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        send(3'd7, 32'hD0000001, 2'd1, 1'b0, 1'b0);
        send(3'd7, 32'hD0000002, 2'd1, 1'b0, 1'b0);
        rst_i = 1'b1;
        clr_i = 1'b0;
        rd_i  = 1'b1;
        tick();
        checks++;
        if (empty_o !== 1'b1 || level_o !== 3'd0 || rd_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got e=%b l=%0d d=%h want e=1 l=0 d=0",
                     empty_o, level_o, rd_data_o);
        end
        send(3'd0, 32'h00000003, 2'd0, 1'b0, 1'b0);
        checks++;
        if (rd_data_o !== 32'h00000003) begin
            errors++;
            $display("FAIL reset_last_addr got %h want 00000003", rd_data_o);
        end
        pop();
    endtask

`ifdef AUD_BTM_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [15:0] t0;
        flush();
        send(3'd0, 32'h1, 2'd0, 1'b0, 1'b0);
        repeat (4) tick();
        send(3'd0, 32'h2, 2'd0, 1'b0, 1'b0);
        t0 = rd_ts_o;
        pop();
        checks++;
        if (rd_ts_o - t0 !== 16'd5) begin
            errors++;
            $display("FAIL ts_delta got %0d want 5", rd_ts_o - t0);
        end
        pop();
    endtask
`endif

    initial begin
        test_reset();
        test_push_one();
        test_rebuild();
        test_overflow();
        test_back_to_back();
        test_clear();
        test_reset_mid();
`ifdef AUD_BTM_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
